regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: DEPTH x WIDTH register file shared by two requesters.
// A round-robin arbiter grants at most one request per cycle. Writes commit
// at the accepting edge; reads return one cycle later on the response port.
module regfile_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_prio;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_hs;
  logic             w_sel_id;
  logic             w_sel_we;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic             w_rd;
  logic             w_wr;

  // Arbitration: a lone requester always wins; on contention prio picks.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant0 = ~r_prio;
      w_grant1 = r_prio;
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end
  end

  // Select the granted request's fields and classify the handshake.
  always_comb begin
    w_hs        = w_grant0 | w_grant1;
    w_sel_id    = w_grant1;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_grant1) begin
      w_sel_we    = req1_we;
      w_sel_addr  = req1_addr;
      w_sel_wdata = req1_wdata;
    end else begin
      w_sel_we    = req0_we;
      w_sel_addr  = req0_addr;
      w_sel_wdata = req0_wdata;
    end
    w_rd = w_hs & ~w_sel_we;
    w_wr = w_hs & w_sel_we;
  end

  // Ready is the grant, forced low while reset is held.
  assign req0_ready = w_grant0 & ~ASYNCRESET;
  assign req1_ready = w_grant1 & ~ASYNCRESET;

  // Round-robin pointer: after a handshake the other requester gets priority.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_prio <= 1'b0;
    end else if (w_hs) begin
      r_prio <= ~w_sel_id;
    end else begin
      r_prio <= r_prio;
    end
  end

  // Storage: cleared by reset, written by the granted write request.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[w_sel_addr] <= w_sel_wdata;
    end else begin
      r_mem <= r_mem;
    end
  end

  // Read response: valid one cycle after an accepted read; id/data hold otherwise.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_rd) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_sel_id;
      r_rsp_data  <= r_mem[w_sel_addr];
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= r_rsp_id;
      r_rsp_data  <= r_rsp_data;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed testbench for regfile_arbiter (WIDTH=8, DEPTH=4).
module tb_regfile_arbiter;

  logic       CLK = 1'b0;
  logic       ASYNCRESET = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req0_we = 1'b0;
  logic [1:0] req0_addr = 2'd0;
  logic [7:0] req0_wdata = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic       req1_we = 1'b0;
  logic [1:0] req1_addr = 2'd0;
  logic [7:0] req1_wdata = 8'h00;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;

  int n_checks = 0;
  int n_fail = 0;

  regfile_arbiter #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_we    = 1'b0;
    req1_we    = 1'b0;
  endtask

  task automatic drive0(input logic we, input logic [1:0] a, input logic [7:0] d);
    req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic we, input logic [1:0] a, input logic [7:0] d);
    req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic pulse_reset();
    ASYNCRESET = 1'b1;
    #1;
    ASYNCRESET = 1'b0;
  endtask

  task automatic test_reset();
    ASYNCRESET = 1'b1;
    drive0(1'b0, 2'd0, 8'h00);
    drive1(1'b0, 2'd0, 8'h00);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== 10'd0) begin
      n_fail++; $display("FAIL reset_rsp: got v=%b id=%b d=%h expected 0/0/00", rsp_valid, rsp_id, rsp_data);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_after_edge: got %b expected 0", rsp_valid);
    end
    idle();
    @(negedge CLK);
    ASYNCRESET = 1'b0;
  endtask

  task automatic test_read_after_reset();
    drive0(1'b0, 2'd3, 8'h00);
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL first_read_ready: got %b expected 1", req0_ready);
    end
    tick();
    idle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL first_read_rsp: got v=%b id=%b d=%h expected 1/0/00", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_write_read();
    drive1(1'b1, 2'd2, 8'hA5);
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ready: got %b expected 1", req1_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_rsp: got %b expected 0", rsp_valid);
    end
    drive1(1'b0, 2'd2, 8'h00);
    tick();
    idle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL wr_then_rd: got v=%b id=%b d=%h expected 1/1/a5", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    drive0(1'b0, 2'd2, 8'h00);
    drive1(1'b0, 2'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, {req0_ready, req1_ready},
                           ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, (i % 2 == 1), 8'h00}) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b id=%b d=%h expected 1/%0d/00", i, rsp_valid, rsp_id, rsp_data, i % 2);
      end
    end
    idle();
  endtask

  task automatic test_conflict();
    drive0(1'b1, 2'd1, 8'h3C);
    drive1(1'b0, 2'd1, 8'h00);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL conflict_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL conflict_hold: got v=%b id=%b d=%h expected 0/1/00", rsp_valid, rsp_id, rsp_data);
    end
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL conflict_second_grant: got %b expected 1", req1_ready);
    end
    tick();
    idle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL conflict_rsp: got v=%b id=%b d=%h expected 1/1/3c", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    drive0(1'b1, 2'd0, 8'h11);
    tick();
    idle();
    drive1(1'b1, 2'd3, 8'h77);
    tick();
    idle();
    // prio is now 0: req0 read wins, req1 write must be discarded
    drive0(1'b0, 2'd3, 8'h00);
    drive1(1'b1, 2'd0, 8'hEE);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_grant0: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h77}) begin
      n_fail++; $display("FAIL b2b_rsp0: got v=%b id=%b d=%h expected 1/0/77", rsp_valid, rsp_id, rsp_data);
    end
    // req1 replaces its pending write with a read; it now has priority
    drive1(1'b0, 2'd0, 8'h00);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_grant1: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    idle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'h11}) begin
      n_fail++; $display("FAIL b2b_rsp1: got v=%b id=%b d=%h expected 1/1/11", rsp_valid, rsp_id, rsp_data);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b1, 8'h11}) begin
      n_fail++; $display("FAIL b2b_idle_hold: got v=%b id=%b d=%h expected 0/1/11", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_reset_inflight();
    drive1(1'b0, 2'd1, 8'h00);
    tick();
    idle();
    n_checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL inflight_pre: got v=%b d=%h expected 1/3c", rsp_valid, rsp_data);
    end
    drive0(1'b0, 2'd1, 8'h00);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data, req0_ready} !== 11'd0) begin
      n_fail++; $display("FAIL inflight_reset: got v=%b id=%b d=%h rdy0=%b expected 0/0/00/0",
                         rsp_valid, rsp_id, rsp_data, req0_ready);
    end
    idle();
    #1;
    ASYNCRESET = 1'b0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL inflight_no_rsp: got %b expected 0", rsp_valid);
    end
    drive0(1'b0, 2'd1, 8'h00);
    tick();
    idle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL inflight_cleared: got v=%b id=%b d=%h expected 1/0/00", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_single_requester();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive1(1'b0, i[1:0], 8'h00);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        n_fail++; $display("FAIL single_ready[%0d]: got %b expected 01", i, {req0_ready, req1_ready});
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
        n_fail++; $display("FAIL single_rsp[%0d]: got v=%b id=%b d=%h expected 1/1/00", i, rsp_valid, rsp_id, rsp_data);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_round_robin();
    test_conflict();
    test_back_to_back();
    test_reset_inflight();
    test_single_requester();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
